// File: rtl/distcalc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : distcalc_sequencer
// Brief    : Chunk-by-chunk controller for the Euclidean distance datapath:
//            fetch, pipe, accumulate, square root, with a stall watchdog.
// Revision : 1.0
// ============================================================================
module distcalc_sequencer #(
    parameter int VARWIDTH  = 32,
    parameter int PIPEWIDTH = 16,
    parameter int MAXCHUNKS = 64,
    parameter int TIMEOUT   = 1024,
    localparam int CNTW     = $clog2(MAXCHUNKS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CNTW:0]       nchunks,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [VARWIDTH-1:0] result,
    output logic                rd_en,
    output logic [CNTW-1:0]     rd_addr,
    input  logic                rd_valid,
    output logic                EN_Pipe,
    output logic                EN_Acc,
    output logic                EN_Sqrt,
    output logic                RST_Acc,
    output logic                RST_Sqrt,
    output logic                PRE_Acc,
    input  logic                RDY_Acc,
    input  logic                RDY_Sqrt,
    input  logic [VARWIDTH-1:0] outval
);

    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [CNTW:0]  c_max_chunks = (CNTW+1)'(MAXCHUNKS);
    localparam logic [WDW-1:0] c_wd_last    = WDW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_FETCH = 3'd2,
        S_PIPE  = 3'd3,
        S_ACC   = 3'd4,
        S_NEXT  = 3'd5,
        S_SQRT  = 3'd6,
        S_FIN   = 3'd7
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [CNTW:0]       r_nchunks;
    logic [CNTW:0]       r_chunk;
    logic [WDW-1:0]      r_wdog;
    logic [VARWIDTH-1:0] r_result;
    logic                r_err;
    logic                w_first;
    logic                w_expired;
    logic                w_timeout;
    logic                w_bad_count;

    // The watchdog is cleared on every state change, so zero marks the first
    // cycle of a wait state; that is when stale ready/valid levels are ignored.
    assign w_first     = (r_wdog == '0);
    assign w_expired   = (r_wdog == c_wd_last);
    assign w_bad_count = (nchunks > c_max_chunks);

    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        rd_en     = 1'b0;
        EN_Pipe   = 1'b0;
        EN_Acc    = 1'b0;
        EN_Sqrt   = 1'b0;
        RST_Acc   = 1'b0;
        RST_Sqrt  = 1'b0;
        PRE_Acc   = 1'b0;
        done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (nchunks == '0 || w_bad_count) w_next = S_FIN;
                    else                              w_next = S_CLR;
                end
            end
            S_CLR: begin
                RST_Acc  = 1'b1;
                RST_Sqrt = 1'b1;
                w_next   = S_FETCH;
            end
            S_FETCH: begin
                rd_en = w_first;
                if (!w_first && rd_valid) begin
                    w_next = S_PIPE;
                end else if (w_expired) begin
                    w_next    = S_FIN;
                    w_timeout = 1'b1;
                end
            end
            S_PIPE: begin
                EN_Pipe = 1'b1;
                w_next  = S_ACC;
            end
            S_ACC: begin
                EN_Pipe = 1'b1;
                EN_Acc  = 1'b1;
                PRE_Acc = (r_chunk != '0);
                if (!w_first && RDY_Acc) begin
                    w_next = S_NEXT;
                end else if (w_expired) begin
                    w_next    = S_FIN;
                    w_timeout = 1'b1;
                end
            end
            S_NEXT: begin
                if ((r_chunk + 1'b1) == r_nchunks) w_next = S_SQRT;
                else                               w_next = S_FETCH;
            end
            S_SQRT: begin
                EN_Sqrt = 1'b1;
                if (!w_first && RDY_Sqrt) begin
                    w_next = S_FIN;
                end else if (w_expired) begin
                    w_next    = S_FIN;
                    w_timeout = 1'b1;
                end
            end
            S_FIN: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_nchunks <= '0;
            r_chunk   <= '0;
            r_wdog    <= '0;
            r_result  <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_wdog <= '0;
            else if (r_state == S_FETCH || r_state == S_ACC || r_state == S_SQRT)
                r_wdog <= r_wdog + 1'b1;

            if (r_state == S_IDLE && start) begin
                r_nchunks <= nchunks;
                r_chunk   <= '0;
                r_result  <= '0;
                r_err     <= w_bad_count;
            end
            if (r_state == S_NEXT)
                r_chunk <= r_chunk + 1'b1;
            // A timeout leaves result at the zero written on accept.
            if (w_timeout)
                r_err <= 1'b1;
            else if (r_state == S_SQRT && w_next == S_FIN)
                r_result <= outval;
        end
    end

    assign busy    = (r_state != S_IDLE);
    assign err     = r_err;
    assign result  = r_result;
    assign rd_addr = r_chunk[CNTW-1:0];

endmodule
`default_nettype wire

// File: tb/tb_distcalc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_distcalc_sequencer
// Brief    : Directed bench with buffer/datapath models and a result scoreboard.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_distcalc_sequencer;
    localparam int VW = 32;
    localparam int MC = 64;
    localparam int CW = 6;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [CW:0]   nchunks = '0;
    logic          busy, done, err, rd_en, rd_valid;
    logic [VW-1:0] result, outval;
    logic [CW-1:0] rd_addr;
    logic          EN_Pipe, EN_Acc, EN_Sqrt, RST_Acc, RST_Sqrt, PRE_Acc;
    logic          RDY_Acc, RDY_Sqrt;

    always #5 clk = ~clk;

    distcalc_sequencer #(
        .VARWIDTH(VW), .PIPEWIDTH(16), .MAXCHUNKS(MC), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .nchunks(nchunks),
        .busy(busy), .done(done), .err(err), .result(result),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid),
        .EN_Pipe(EN_Pipe), .EN_Acc(EN_Acc), .EN_Sqrt(EN_Sqrt),
        .RST_Acc(RST_Acc), .RST_Sqrt(RST_Sqrt), .PRE_Acc(PRE_Acc),
        .RDY_Acc(RDY_Acc), .RDY_Sqrt(RDY_Sqrt), .outval(outval)
    );

    // Vector buffer and datapath models
    logic [VW-1:0] mem [0:MC-1];
    int            rv_delay = 1;
    int            rv_cnt;
    logic          force_hi = 1'b0;
    logic          stuck = 1'b0;
    logic [VW-1:0] cur_data, sum;
    logic          en_acc_d;

    assign outval = sum;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_valid <= 1'b0; rv_cnt <= 0; cur_data <= '0; sum <= '0;
            en_acc_d <= 1'b0; RDY_Acc <= 1'b0; RDY_Sqrt <= 1'b0;
        end else begin
            if (rd_en) begin
                rv_cnt   <= rv_delay - 1;
                rd_valid <= (rv_delay == 1);
            end else if (rv_cnt > 0) begin
                rv_cnt   <= rv_cnt - 1;
                rd_valid <= (rv_cnt == 1);
            end else begin
                rd_valid <= 1'b0;
            end
            if (rd_valid) cur_data <= mem[rd_addr];
            if (RST_Acc) sum <= '0;
            else if (EN_Acc && !en_acc_d) sum <= PRE_Acc ? sum + cur_data : cur_data;
            en_acc_d <= EN_Acc;
            RDY_Acc  <= force_hi | (!stuck & EN_Acc);
            RDY_Sqrt <= EN_Sqrt;
        end
    end

    typedef struct {
        logic [VW-1:0] res;
        logic          e;
        int            lat;
    } exp_t;
    exp_t          sb[$];
    logic [CW-1:0] addr_seen[$];
    logic          pre_seen[$];

    int errors = 0;
    int checks = 0;
    int lat, rd_cnt, rst_cnt, en_cnt, pipe_early, excl_viol, acc_run, acc_min, acc_max;
    logic pending;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one request, monitors handshakes until done, and scores the result.
    // exp_lat < 0 accepts a done within two cycles of accept.
    task automatic run(input int n, input int exp_lat, input logic [VW-1:0] exp_res,
                       input logic exp_err, input bit poke);
        exp_t e;
        bit   got;
        sb.push_back('{exp_res, exp_err, exp_lat});
        addr_seen.delete(); pre_seen.delete();
        rd_cnt = 0; rst_cnt = 0; en_cnt = 0; pipe_early = 0; excl_viol = 0;
        acc_run = 0; acc_min = 1000; acc_max = 0; pending = 1'b0; lat = 0; got = 0;
        @(negedge clk); start = 1'b1; nchunks = n[CW:0];
        @(posedge clk); #1 start = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            start = poke && (c == 3 || c == 8);
            if (start) nchunks = 7'd1;
            if (rd_en) begin addr_seen.push_back(rd_addr); rd_cnt++; pending = 1'b1; end
            if (rd_valid) pending = 1'b0;
            if (EN_Pipe && pending) pipe_early++;
            if (RST_Acc) rst_cnt++;
            if (rd_en | EN_Pipe | EN_Acc | EN_Sqrt) en_cnt++;
            if (int'(RST_Acc | RST_Sqrt) + int'(EN_Pipe & !EN_Acc) + int'(EN_Acc) + int'(EN_Sqrt) > 1)
                excl_viol++;
            if (!busy) excl_viol++;
            if (EN_Acc) begin
                acc_run++;
                if (acc_run == 1) pre_seen.push_back(PRE_Acc);
            end else if (acc_run > 0) begin
                if (acc_run < acc_min) acc_min = acc_run;
                if (acc_run > acc_max) acc_max = acc_run;
                acc_run = 0;
            end
            if (done) begin lat = c; got = 1; break; end
        end
        if (poke) begin
            start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        e = sb.pop_front();
        if (!got) begin
            check("done_timeout", 64'd0, 64'd1);
        end else begin
            if (e.lat < 0) check("latency_short", 64'(lat >= 1 && lat <= 2), 64'd1);
            else           check("latency", 64'(lat), 64'(e.lat));
            check("result", 64'(result), 64'(e.res));
            check("err", 64'(err), 64'(e.e));
        end
        check("handshake_exclusive", 64'(excl_viol), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < MC; i++) mem[i] = '0;
        mem[0] = 32'h0000_0005;
        mem[1] = 32'h0000_0100;
        mem[2] = 32'h0000_2000;

        repeat (3) @(negedge clk);
        check("reset_outputs",
              {16'd0, busy, done, err, rd_en, EN_Pipe, EN_Acc, EN_Sqrt, RST_Acc, RST_Sqrt,
               PRE_Acc, result, rd_addr}, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Single chunk
        run(1, 10, 32'h5, 1'b0, 0);
        check("n1_rd_count", 64'(rd_cnt), 64'd1);
        check("n1_addr0", 64'(addr_seen.size() > 0 ? addr_seen[0] : 6'h3f), 64'd0);
        check("n1_pre", 64'(pre_seen.size() > 0 ? pre_seen[0] : 1'b1), 64'd0);
        check("n1_rst_acc", 64'(rst_cnt), 64'd1);

        // Three chunks accumulate across the pipe
        run(3, 22, 32'h2105, 1'b0, 0);
        check("n3_rd_count", 64'(addr_seen.size()), 64'd3);
        for (int i = 0; i < 3; i++) begin
            check("n3_addr", 64'(addr_seen.size() > i ? addr_seen[i] : 6'h3f), 64'(i));
            check("n3_pre", 64'(pre_seen.size() > i ? pre_seen[i] : 1'bx), 64'(i > 0));
        end
        check("n3_rst_acc", 64'(rst_cnt), 64'd1);

        // Degenerate counts
        run(0, -1, 32'h0, 1'b0, 0);
        check("n0_no_activity", 64'(en_cnt), 64'd0);
        run(MC + 1, -1, 32'h0, 1'b1, 0);
        check("nbad_no_activity", 64'(en_cnt), 64'd0);

        // Stalled accumulator trips the watchdog; next request recovers
        stuck = 1'b1;
        run(1, 21, 32'h0, 1'b1, 0);
        check("wd_acc_cycles", 64'(acc_max), 64'(TO));
        stuck = 1'b0;
        run(2, 16, 32'h105, 1'b0, 0);

        // Slow buffer and stale ready on ACC entry
        rv_delay = 5; force_hi = 1'b1;
        run(1, 14, 32'h5, 1'b0, 0);
        check("slow_no_early_pipe", 64'(pipe_early), 64'd0);
        check("slow_acc_min2", 64'(acc_min >= 2), 64'd1);
        rv_delay = 1; force_hi = 1'b0;

        // Start pulses while busy and in the done cycle are ignored
        run(3, 22, 32'h2105, 1'b0, 1);
        begin
            int extra = 0;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                if (busy || done) extra++;
            end
            check("ignored_starts", 64'(extra), 64'd0);
        end

        // Reset in the middle of the square-root phase
        begin
            int seen = 0, dcount = 0;
            @(negedge clk); start = 1'b1; nchunks = 7'd1;
            @(posedge clk); #1 start = 1'b0;
            for (int c = 0; c < 50 && !seen; c++) begin
                @(negedge clk);
                if (EN_Sqrt) seen = 1;
                if (done) dcount++;
            end
            check("reached_sqrt", 64'(seen), 64'd1);
            #2 rst = 1'b0;
            #1;
            check("async_reset_outputs",
                  {16'd0, busy, done, err, rd_en, EN_Pipe, EN_Acc, EN_Sqrt, RST_Acc, RST_Sqrt,
                   PRE_Acc, result, rd_addr}, 64'd0);
            repeat (2) @(negedge clk);
            rst = 1'b1;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (done) dcount++;
            end
            check("no_done_after_reset", 64'(dcount), 64'd0);
            check("idle_after_reset", 64'(busy), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1);
    end
endmodule
`default_nettype wire
